sd_cmd_seq: RTL
===============

# sd_cmd_seq

SD-card command sequencer for the RK8E Secure Digital disk interface. It drives the SPI byte engine through `spiOP_t` operations: chip-select control, a leading dummy byte, the 6-byte SD command frame, R1 response polling, and an optional chip-select release with a trailing dummy byte. The RK8E disk controller FSM sits above it and issues one command per `start`. The SPI byte engine sits below it and executes each operation.

## Interface
Parameters:
- `NCR_MAX`, default 8: maximum number of response-poll bytes before timeout (range 1–255).

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle command request; sampled only in IDLE
- `cmd_idx`  in  6  SD command index; captured on an accepted `start`
- `cmd_arg`  in  32  command argument; captured on an accepted `start`
- `keep_cs`  in  1  captured on `start`; 1 leaves CS low after R1 so a data phase can follow
- `spi_op`  out  `spiOP_t`  operation request to the SPI engine; non-NOP for exactly one cycle per request
- `spi_txd`  out  8  transmit byte; valid with `spi_op==spiTR`
- `spi_rxd`  in  8  byte received by the engine; valid when `spi_done` is high
- `spi_done`  in  1  one-cycle pulse from the engine when the requested operation has completed
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE state
- `done`  out  1  one-cycle completion pulse
- `r1`  out  8  R1 response; 0xFF on timeout
- `timeout`  out  1  set with `done` when no R1 arrived within `NCR_MAX` polls; held until the next `start`

## Operation
- States: IDLE, CSL, PRE, CMD, RSP, CSH, POST, DONE.
- Every state except IDLE and DONE has an issue cycle and a wait phase:
  - Issue cycle: the state's op is driven on `spi_op`.
  - Wait phase: `spi_op=spiNOP` until `spi_done` arrives.
- State sequence:
  - IDLE: on `start`, capture the inputs, clear `timeout`, go to CSL.
  - CSL: issue `spiCSL`, then go to PRE.
  - PRE: issue `spiTR` with 0xFF, then go to CMD.
  - CMD: send 6 bytes, indexed by byte counter 0–5:
    - byte 0: `{2'b01, cmd_idx}`
    - bytes 1–4: `cmd_arg[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`
    - byte 5: `{crc7, 1'b1}`
    - After byte 5's `spi_done`, clear the poll counter and go to RSP.
  - RSP: issue `spiTR` with 0xFF, then on `spi_done`:
    - `spi_rxd[7]==0`: latch `r1=spi_rxd`.
    - Otherwise, after the `NCR_MAX`-th poll: set `r1=0xFF` and `timeout=1`.
    - Otherwise: increment the poll counter and re-issue.
    - On exit: go to DONE if `keep_cs==1`, else go to CSH.
  - CSH: issue `spiCSH`, then go to POST.
  - POST: issue `spiTR` with 0xFF, then go to DONE.
  - DONE: pulse `done` for one cycle, go to IDLE.
- CRC7 (polynomial x^7+x^3+1, initial value 0):
  - Updated byte-wise as each of bytes 0–4 is loaded into `spi_txd`.
  - Complete before byte 5 is issued.
- Ignored events:
  - `start` while not in IDLE.
  - `spi_done` outside a wait phase.
  - `spi_rxd` when `spi_done` is low.
- The poll counter is 8 bits and does not wrap: the `NCR_MAX` compare terminates polling first.

## Timing
- Reset values: `spi_op=spiNOP`, `spi_txd=0xFF`, `busy=0`, `done=0`, `r1=0xFF`, `timeout=0`, state IDLE.
- Accepted `start` at cycle N:
  - `busy=1` at N+1.
  - `spi_op=spiCSL` at N+1.
- Each `spi_done` at cycle M produces the next op's issue cycle at M+1. There are no idle gaps beyond this 1-cycle turnaround.
- `done`, final `r1` and final `timeout` appear in the cycle after the last `spi_done`; `busy` drops in the cycle after `done`.
- `r1` and `timeout` remain stable from `done` until the next accepted `start`.
- `spi_txd` holds its value throughout each wait phase.
- Reset mid-operation:
  - Returns to IDLE immediately, with `spi_op=spiNOP` in the next cycle.
  - No CSH is issued; the parent is responsible for CS recovery.
- Reset asserted in the same cycle as `start`: reset wins.

## Configuration
- `SDCMD_CRC_EN` defined: byte 5 is the computed `{crc7,1}` for every command.
- `SDCMD_CRC_EN` undefined: the CRC logic is removed and byte 5 is fixed:
  - 0x95 for CMD0
  - 0x87 for CMD8
  - 0x01 for all other commands (SPI mode ignores CRC after CMD8).

## Test plan
- CMD0, arg 0, engine returns 0xFF then 0x01 → op stream CSL, TR 0xFF, TR 40 00 00 00 00 95, TR 0xFF ×2, CSH, TR 0xFF; `r1=0x01`, `timeout=0`, one `done` pulse.
- CMD8, arg 0x000001AA, with and without `SDCMD_CRC_EN` → byte 5 = 0x87; R1 0x01 latched.
- `NCR_MAX=8`, engine always returns 0xFF → exactly 8 RSP TR ops, then CSH and POST; `r1=0xFF`, `timeout=1`.
- CMD17 with `keep_cs=1`, R1 0x00 on first poll → no CSH and no POST issued; `done` follows the RSP `spi_done` by 1 cycle.
- `start` pulsed during CMD byte 3, plus a stray `spi_done` during an issue cycle → both ignored; op stream unchanged.
- `reset_n` low during RSP → next cycle `spi_op=spiNOP`, `busy=0`, `r1=0xFF`; a new CMD0 then completes normally.

Source files
------------

// File: rtl/sd_cmd_seq.sv
// SD-card SPI command sequencer: CS control, dummy bytes, 6-byte frame, R1 polling.
// Build option: define SDCMD_CRC_EN to compute CRC7 for byte 5; otherwise byte 5 is a fixed table value.

package sd_cmd_seq_pkg;
  typedef enum logic [2:0] {
    spiNOP  = 3'd0,
    spiCSL  = 3'd1,
    spiCSH  = 3'd2,
    spiFAST = 3'd3,
    spiSLOW = 3'd4,
    spiTR   = 3'd5
  } spiOP_t;
endpackage

module sd_cmd_seq
  import sd_cmd_seq_pkg::*;
#(
  parameter int unsigned NCR_MAX = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  cmd_idx,
  input  logic [31:0] cmd_arg,
  input  logic        keep_cs,
  output spiOP_t      spi_op,
  output logic [7:0]  spi_txd,
  input  logic [7:0]  spi_rxd,
  input  logic        spi_done,
  output logic        busy,
  output logic        done,
  output logic [7:0]  r1,
  output logic        timeout
);

  localparam int unsigned POLL_W = 8;
  localparam logic [7:0]  DUMMY  = 8'hFF;
  localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(NCR_MAX - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CSL, S_PRE, S_CMD, S_RSP, S_CSH, S_POST, S_DONE
  } state_t;

  state_t            state_q, state_d;
  spiOP_t            op_q, op_d;
  logic [7:0]        txd_q, txd_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [7:0]        r1_q, r1_d;
  logic              to_q, to_d;
  logic [5:0]        idx_q, idx_d;
  logic [31:0]       arg_q, arg_d;
  logic              keep_q, keep_d;
  logic [2:0]        byte_q, byte_d;
  logic [POLL_W-1:0] poll_q, poll_d;
  logic [7:0]        b5_c;
  logic              ev_c;

  // A completion only counts in a wait phase, never in the issue cycle.
  assign ev_c = spi_done && (op_q == spiNOP);

  function automatic logic [7:0] frame_byte(input logic [2:0]  sel,
                                            input logic [5:0]  idx,
                                            input logic [31:0] arg,
                                            input logic [7:0]  b5);
    case (sel)
      3'd0:    frame_byte = {2'b01, idx};
      3'd1:    frame_byte = arg[31:24];
      3'd2:    frame_byte = arg[23:16];
      3'd3:    frame_byte = arg[15:8];
      3'd4:    frame_byte = arg[7:0];
      default: frame_byte = b5;
    endcase
  endfunction

`ifdef SDCMD_CRC_EN
  logic [6:0] crc_q, crc_d;

  function automatic logic [6:0] crc7_byte(input logic [6:0] crc, input logic [7:0] data);
    logic [6:0] c;
    logic       fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[6] ^ data[i];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // CRC follows bytes 0-4 as they are loaded into the transmit register.
  always_comb begin
    crc_d = crc_q;
    if (state_q == S_IDLE && start) begin
      crc_d = '0;
    end else if (ev_c && (state_q == S_PRE || (state_q == S_CMD && byte_q < 3'd4))) begin
      crc_d = crc7_byte(crc_q, txd_d);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  assign b5_c = {crc_q, 1'b1};
`else
  always_comb begin
    b5_c = 8'h01;
    if (idx_q == 6'd0)      b5_c = 8'h95;
    else if (idx_q == 6'd8) b5_c = 8'h87;
  end
`endif

  always_comb begin
    state_d = state_q;
    op_d    = spiNOP;
    txd_d   = txd_q;
    done_d  = 1'b0;
    r1_d    = r1_q;
    to_d    = to_q;
    idx_d   = idx_q;
    arg_d   = arg_q;
    keep_d  = keep_q;
    byte_d  = byte_q;
    poll_d  = poll_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = cmd_idx;
          arg_d   = cmd_arg;
          keep_d  = keep_cs;
          to_d    = 1'b0;
          op_d    = spiCSL;
          state_d = S_CSL;
        end
      end
      S_CSL: begin
        if (ev_c) begin
          op_d    = spiTR;
          txd_d   = DUMMY;
          state_d = S_PRE;
        end
      end
      S_PRE: begin
        if (ev_c) begin
          byte_d  = 3'd0;
          op_d    = spiTR;
          txd_d   = frame_byte(3'd0, idx_q, arg_q, b5_c);
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (ev_c) begin
          op_d = spiTR;
          if (byte_q == 3'd5) begin
            poll_d  = '0;
            txd_d   = DUMMY;
            state_d = S_RSP;
          end else begin
            byte_d = byte_q + 3'd1;
            txd_d  = frame_byte(byte_q + 3'd1, idx_q, arg_q, b5_c);
          end
        end
      end
      S_RSP: begin
        // Poll until a byte with MSB clear arrives or the poll budget is spent.
        if (ev_c) begin
          if (!spi_rxd[7] || poll_q == POLL_LAST) begin
            r1_d = spi_rxd[7] ? 8'hFF : spi_rxd;
            to_d = spi_rxd[7];
            if (keep_q) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              op_d    = spiCSH;
              state_d = S_CSH;
            end
          end else begin
            poll_d = poll_q + POLL_W'(1);
            op_d   = spiTR;
            txd_d  = DUMMY;
          end
        end
      end
      S_CSH: begin
        if (ev_c) begin
          op_d    = spiTR;
          txd_d   = DUMMY;
          state_d = S_POST;
        end
      end
      S_POST: begin
        if (ev_c) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      op_q    <= spiNOP;
      txd_q   <= DUMMY;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      r1_q    <= 8'hFF;
      to_q    <= 1'b0;
      idx_q   <= '0;
      arg_q   <= '0;
      keep_q  <= 1'b0;
      byte_q  <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r1_q    <= r1_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
      arg_q   <= arg_d;
      keep_q  <= keep_d;
      byte_q  <= byte_d;
      poll_q  <= poll_d;
    end
  end

  assign spi_op  = op_q;
  assign spi_txd = txd_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign r1      = r1_q;
  assign timeout = to_q;

endmodule
